// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Four-digit multiplexed 7-segment display driver. A 16-bit hex value is
// double-buffered (shadow -> active) and time-multiplexed onto active-low
// anodes and segments. A blanking gap with every anode off separates the
// digits so that one digit's segment pattern never ghosts onto the next.
// This is the last stage before the board pins, so every output is a flop.
//
// Optional build macro:
//   SEG7_DP_EN  - adds a per-digit decimal point (dp_in / dp), buffered
//                 exactly like the hex data.
//
// Parameters:
//   PRESCALE_W    width of the per-digit on-time counter; a digit is lit for
//                 exactly 2**PRESCALE_W cycles
//   BLANK_CYCLES  cycles with all anodes off between digits (1..255)
//
// Ports:
//   clkin    in   1   scan clock (divided clock from the clock-management stage)
//   rst_n    in   1   asynchronous active-low reset
//   enable   in   1   1 = drive display, 0 = force all anodes/segments off
//   load     in   1   capture data_in into the shadow register this cycle
//   data_in  in  16   four hex nibbles, [3:0] is digit 0 (rightmost)
//   dp_in    in   4   decimal points per digit (SEG7_DP_EN only)
//   an       out  4   anode enables, active-low, one-hot-low while showing
//   seg      out  7   {g,f,e,d,c,b,a}, active-low
//   dp       out  1   decimal point, active-low (SEG7_DP_EN only)
//   frame    out  1   one-cycle pulse at each frame boundary
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int PRESCALE_W   = 10,
   parameter int BLANK_CYCLES = 4
) (
   input  logic        clkin,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] data_in,
`ifdef SEG7_DP_EN
   input  logic [3:0]  dp_in,
   output logic        dp,
`endif
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        frame
);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   localparam logic [7:0]            BLANK_LAST = 8'(BLANK_CYCLES - 1);
   localparam logic [PRESCALE_W-1:0] PRE_LAST   = '1;
   localparam logic [PRESCALE_W-1:0] PRE_ONE    = 1;

   state_t                state_reg;
   logic [7:0]            blank_cnt_reg;
   logic [PRESCALE_W-1:0] pre_cnt_reg;
   logic [1:0]            idx_reg;
   logic [15:0]           shadow_reg;
   logic [15:0]           active_reg;
   logic [3:0]            an_reg;
   logic [6:0]            seg_reg;
   logic                  frame_reg;
`ifdef SEG7_DP_EN
   logic [3:0]            dp_shadow_reg;
   logic [3:0]            dp_active_reg;
   logic                  dp_reg;
`endif

   // Pattern for the digit currently selected by idx_reg; the FSM decides
   // whether it actually reaches the pins.
   logic [3:0] an_show_next;
   logic [6:0] seg_show_next;
   logic [3:0] nibble_next;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_anode
         assign an_show_next[gi] = (idx_reg != 2'(gi));
      end
   endgenerate

   always_comb begin
      nibble_next = active_reg[{idx_reg, 2'b00} +: 4];
      seg_show_next = 7'b1111111;
      case (nibble_next)
         4'h0: seg_show_next = 7'b1000000;
         4'h1: seg_show_next = 7'b1111001;
         4'h2: seg_show_next = 7'b0100100;
         4'h3: seg_show_next = 7'b0110000;
         4'h4: seg_show_next = 7'b0011001;
         4'h5: seg_show_next = 7'b0010010;
         4'h6: seg_show_next = 7'b0000010;
         4'h7: seg_show_next = 7'b1111000;
         4'h8: seg_show_next = 7'b0000000;
         4'h9: seg_show_next = 7'b0010000;
         4'hA: seg_show_next = 7'b0001000;
         4'hB: seg_show_next = 7'b0000011;
         4'hC: seg_show_next = 7'b1000110;
         4'hD: seg_show_next = 7'b0100001;
         4'hE: seg_show_next = 7'b0000110;
         4'hF: seg_show_next = 7'b0001110;
         default: seg_show_next = 7'b1111111;
      endcase
   end

   // Scan FSM. Outputs are registered alongside the state they belong to, so
   // an/seg always describe the state being entered on this edge.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_BLANK;
         blank_cnt_reg <= '0;
         pre_cnt_reg   <= '0;
         idx_reg       <= 2'd0;
         shadow_reg    <= 16'h0000;
         active_reg    <= 16'h0000;
         an_reg        <= 4'b1111;
         seg_reg       <= 7'b1111111;
         frame_reg     <= 1'b0;
`ifdef SEG7_DP_EN
         dp_shadow_reg <= 4'b0000;
         dp_active_reg <= 4'b0000;
         dp_reg        <= 1'b1;
`endif
      end else begin
         frame_reg <= 1'b0;

         // Shadow capture is independent of the scan; at a frame boundary the
         // active register below still samples the pre-load shadow value.
         if (load) begin
            shadow_reg <= data_in;
`ifdef SEG7_DP_EN
            dp_shadow_reg <= dp_in;
`endif
         end

         case (state_reg)
            ST_BLANK: begin
               if (blank_cnt_reg == BLANK_LAST) begin
                  state_reg     <= ST_SHOW;
                  blank_cnt_reg <= '0;
                  pre_cnt_reg   <= '0;
                  an_reg        <= enable ? an_show_next  : 4'b1111;
                  seg_reg       <= enable ? seg_show_next : 7'b1111111;
`ifdef SEG7_DP_EN
                  dp_reg        <= enable ? ~dp_active_reg[idx_reg] : 1'b1;
`endif
               end else begin
                  blank_cnt_reg <= blank_cnt_reg + 8'd1;
                  an_reg        <= 4'b1111;
                  seg_reg       <= 7'b1111111;
`ifdef SEG7_DP_EN
                  dp_reg        <= 1'b1;
`endif
               end
            end

            ST_SHOW: begin
               if (pre_cnt_reg == PRE_LAST) begin
                  state_reg   <= ST_BLANK;
                  pre_cnt_reg <= '0;
                  idx_reg     <= idx_reg + 2'd1;
                  an_reg      <= 4'b1111;
                  seg_reg     <= 7'b1111111;
`ifdef SEG7_DP_EN
                  dp_reg      <= 1'b1;
`endif
                  // Last digit finished: frame boundary.
                  if (idx_reg == 2'd3) begin
                     frame_reg  <= 1'b1;
                     active_reg <= shadow_reg;
`ifdef SEG7_DP_EN
                     dp_active_reg <= dp_shadow_reg;
`endif
                  end
               end else begin
                  pre_cnt_reg <= pre_cnt_reg + PRE_ONE;
                  an_reg      <= enable ? an_show_next  : 4'b1111;
                  seg_reg     <= enable ? seg_show_next : 7'b1111111;
`ifdef SEG7_DP_EN
                  dp_reg      <= enable ? ~dp_active_reg[idx_reg] : 1'b1;
`endif
               end
            end

            default: begin
               state_reg <= ST_BLANK;
               an_reg    <= 4'b1111;
               seg_reg   <= 7'b1111111;
            end
         endcase
      end
   end

   assign an    = an_reg;
   assign seg   = seg_reg;
   assign frame = frame_reg;
`ifdef SEG7_DP_EN
   assign dp    = dp_reg;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver with PRESCALE_W=2, BLANK_CYCLES=2:
// each digit slot is 2 blank + 4 show cycles, a frame is 24 cycles.
// k counts rising edges since reset release; expected anode/segment/frame
// values are derived from k with the hand-worked slot arithmetic below.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

   logic        clkin   = 1'b0;
   logic        rst_n   = 1'b0;
   logic        enable  = 1'b1;
   logic        load    = 1'b0;
   logic [15:0] data_in = 16'h0000;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame;
`ifdef SEG7_DP_EN
   logic [3:0]  dp_in = 4'b0000;
   logic        dp;
`endif

   int tests_run    = 0;
   int tests_failed = 0;
   int k            = 0;

   always #5 clkin = ~clkin;

   seg7_scan_driver #(
      .PRESCALE_W   (2),
      .BLANK_CYCLES (2)
   ) dut (
      .clkin   (clkin),
      .rst_n   (rst_n),
      .enable  (enable),
      .load    (load),
      .data_in (data_in),
`ifdef SEG7_DP_EN
      .dp_in   (dp_in),
      .dp      (dp),
`endif
      .an      (an),
      .seg     (seg),
      .frame   (frame)
   );

   // Segment table, active-low {g..a}.
   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // Slot position r within a 6-cycle digit slot: r=0,1 blank, r=2..5 show.
   function automatic logic [3:0] exp_an(input int kk);
      int p;
      int d;
      p = kk % 24;
      d = p / 6;
      if ((p % 6) < 2) return 4'b1111;
      return ~(4'b0001 << d);
   endfunction

   function automatic logic [6:0] exp_seg(input int kk, input logic [15:0] v);
      int d;
      d = (kk % 24) / 6;
      if (((kk % 24) % 6) < 2) return 7'b1111111;
      return seg_of(v[4*d +: 4]);
   endfunction

   function automatic logic exp_frame(input int kk);
      return (kk > 0) && ((kk % 24) == 0);
   endfunction

   task automatic tick;
      @(posedge clkin);
      #1;
      k++;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      load  = 1'b0;
      enable = 1'b1;
      tick;
      tick;
      rst_n = 1'b1;
      k = 0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick;
      tick;
      tests_run++;
      if (an !== 4'b1111) begin
         tests_failed++;
         $display("FAIL reset_an: got %b expected 1111", an);
      end
      tests_run++;
      if (seg !== 7'b1111111) begin
         tests_failed++;
         $display("FAIL reset_seg: got %b expected 1111111", seg);
      end
      tests_run++;
      if (frame !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_frame: got %b expected 0", frame);
      end
      rst_n = 1'b1;
      k = 0;
      repeat (50) begin
         tick;
         tests_run++;
         if (an !== exp_an(k) || seg !== exp_seg(k, 16'h0000) || frame !== exp_frame(k)) begin
            tests_failed++;
            $display("FAIL reset_scan k=%0d: got an=%b seg=%b frame=%b expected an=%b seg=%b frame=%b",
                     k, an, seg, frame, exp_an(k), exp_seg(k, 16'h0000), exp_frame(k));
         end
      end
      $display("[TB] test_reset: reset state and release scan pattern checked");
   endtask

   task automatic test_load_mid_frame;
      logic [15:0] v;
      do_reset;
      while (k < 10) tick;
      load = 1'b1;
      data_in = 16'h8A10;
      tick;
      load = 1'b0;
      data_in = 16'h0000;
      while (k < 48) begin
         tick;
         v = (k <= 24) ? 16'h0000 : 16'h8A10;
         tests_run++;
         if (an !== exp_an(k) || seg !== exp_seg(k, v) || frame !== exp_frame(k)) begin
            tests_failed++;
            $display("FAIL load_mid_frame k=%0d: got an=%b seg=%b frame=%b expected an=%b seg=%b frame=%b",
                     k, an, seg, frame, exp_an(k), exp_seg(k, v), exp_frame(k));
         end
      end
      $display("[TB] test_load_mid_frame: 8A10 shown from the frame after the load");
   endtask

   task automatic test_load_on_frame;
      logic [15:0] v;
      do_reset;
      while (k < 5) tick;
      load = 1'b1;
      data_in = 16'h2222;
      tick;
      load = 1'b0;
      while (k < 23) tick;
      load = 1'b1;
      data_in = 16'h1111;
      tick;
      load = 1'b0;
      data_in = 16'h0000;
      tests_run++;
      if (frame !== 1'b1) begin
         tests_failed++;
         $display("FAIL load_on_frame_pulse k=%0d: got frame=%b expected 1", k, frame);
      end
      while (k < 72) begin
         tick;
         v = (k <= 48) ? 16'h2222 : 16'h1111;
         tests_run++;
         if (an !== exp_an(k) || seg !== exp_seg(k, v) || frame !== exp_frame(k)) begin
            tests_failed++;
            $display("FAIL load_on_frame k=%0d: got an=%b seg=%b frame=%b expected an=%b seg=%b frame=%b",
                     k, an, seg, frame, exp_an(k), exp_seg(k, v), exp_frame(k));
         end
      end
      $display("[TB] test_load_on_frame: 2222 then 1111 across consecutive frames");
   endtask

   task automatic test_enable;
      logic       en;
      logic [3:0] ea;
      logic [6:0] es;
      do_reset;
      load = 1'b1;
      data_in = 16'h5A3C;
      tick;
      load = 1'b0;
      while (k < 27) tick;
      enable = 1'b0;
      while (k < 60) begin
         tick;
         en = !(k >= 28 && k <= 37);
         ea = en ? exp_an(k) : 4'b1111;
         es = en ? exp_seg(k, (k <= 24) ? 16'h0000 : 16'h5A3C) : 7'b1111111;
         tests_run++;
         if (an !== ea || seg !== es || frame !== exp_frame(k)) begin
            tests_failed++;
            $display("FAIL enable k=%0d: got an=%b seg=%b frame=%b expected an=%b seg=%b frame=%b",
                     k, an, seg, frame, ea, es, exp_frame(k));
         end
         if (k == 37) enable = 1'b1;
      end
      $display("[TB] test_enable: blanking while disabled, scan resumes mid-frame");
   endtask

   task automatic test_async_reset;
      do_reset;
      load = 1'b1;
      data_in = 16'h1234;
      tick;
      load = 1'b0;
      data_in = 16'h0000;
      while (k < 39) tick;
      tests_run++;
      if (an !== 4'b1011 || seg !== 7'b0100100) begin
         tests_failed++;
         $display("FAIL async_pre k=%0d: got an=%b seg=%b expected an=1011 seg=0100100", k, an, seg);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || frame !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: got an=%b seg=%b frame=%b expected an=1111 seg=1111111 frame=0",
                  an, seg, frame);
      end
      tick;
      rst_n = 1'b1;
      k = 0;
      repeat (30) begin
         tick;
         tests_run++;
         if (an !== exp_an(k) || seg !== exp_seg(k, 16'h0000) || frame !== exp_frame(k)) begin
            tests_failed++;
            $display("FAIL async_release k=%0d: got an=%b seg=%b frame=%b expected an=%b seg=%b frame=%b",
                     k, an, seg, frame, exp_an(k), exp_seg(k, 16'h0000), exp_frame(k));
         end
      end
      $display("[TB] test_async_reset: immediate blanking, restart at digit 0 with 0000");
   endtask

`ifdef SEG7_DP_EN
   task automatic test_dp;
      logic ed;
      do_reset;
      load = 1'b1;
      dp_in = 4'b0101;
      tick;
      load = 1'b0;
      dp_in = 4'b0000;
      while (k < 48) begin
         tick;
         if (k <= 24 || exp_an(k) == 4'b1111) ed = 1'b1;
         else ed = ~((((k % 24) / 6) % 2) == 0);
         tests_run++;
         if (dp !== ed) begin
            tests_failed++;
            $display("FAIL dp k=%0d: got dp=%b expected %b", k, dp, ed);
         end
      end
      $display("[TB] test_dp: decimal points on digits 0 and 2");
   endtask
`endif

   initial begin
      test_reset;
      test_load_mid_frame;
      test_load_on_frame;
      test_enable;
      test_async_reset;
`ifdef SEG7_DP_EN
      test_dp;
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
